// File: rtl/my9262_serializer.sv
// ---------------------------------------------------------------------------
// my9262_serializer
//
// Shifts 16-bit grayscale words MSB-first onto the MY9262 DI/DCK pins and,
// after every CHAIN_WORDS words, runs the internal-latch sequence: a quiet
// period with DI=0/DCK=0, then LATCH_PULSES DI pulses with DCK held low.
//
// Ports
//   csi_clk            system clock
//   rsi_reset          synchronous, active-high reset
//   my9262_Data        word to shift, captured only when a start is accepted
//   my9262_Start       one-cycle start strobe for one word
//   my9262_DI          serial data / latch pulses
//   my9262_DCK         serial clock
//   my9262_Busy        high while shifting or latching
//   my9262_WordDone    one-cycle pulse after each word's final DCK-high phase
//   my9262_FrameDone   one-cycle pulse at the end of the latch sequence
//   my9262_Overrun     sticky flag, set by a start that arrives while busy
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | waiting for a start; DI=DCK=0, Busy=0
// ST_SHIFT_LO   | DCK low, DI holds the current MSB (setup phase)
// ST_SHIFT_HI   | DCK high, DI stable; shift on exit
// ST_LATCH_WAIT | quiet period before the latch pulses, DI=DCK=0
// ST_LATCH_HI   | latch pulse high, DCK low
// ST_LATCH_LO   | latch pulse low, DCK low
// ---------------------------------------------------------------------------
module my9262_serializer #(
   parameter int CLK_DIV      = 4,
   parameter int CHAIN_WORDS  = 16,
   parameter int LATCH_WAIT   = 64,
   parameter int LATCH_PULSES = 4
) (
   input  logic        csi_clk,
   input  logic        rsi_reset,
   input  logic [15:0] my9262_Data,
   input  logic        my9262_Start,
   output logic        my9262_DI,
   output logic        my9262_DCK,
   output logic        my9262_Busy,
   output logic        my9262_WordDone,
   output logic        my9262_FrameDone,
   output logic        my9262_Overrun
);

   // One shared down-counter times every phase, so it must cover the longer
   // of a DCK half-period and the quiet period. It is loaded with length-1
   // on phase entry and the phase ends at terminal count zero.
   localparam int T_MAX = (CLK_DIV > LATCH_WAIT) ? CLK_DIV : LATCH_WAIT;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int WCW   = (CHAIN_WORDS > 1) ? $clog2(CHAIN_WORDS) : 1;
   localparam int PCW   = (LATCH_PULSES > 1) ? $clog2(LATCH_PULSES) : 1;

   localparam logic [TW-1:0]  DIV_LOAD   = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0]  WAIT_LOAD  = TW'(LATCH_WAIT - 1);
   localparam logic [WCW-1:0] WORD_LAST  = WCW'(CHAIN_WORDS - 1);
   localparam logic [PCW-1:0] PULSE_LAST = PCW'(LATCH_PULSES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_LATCH_WAIT,
      ST_LATCH_HI,
      ST_LATCH_LO
   } state_t;

   state_t         state, state_n;
   logic [15:0]    shreg, shreg_n;
   logic [TW-1:0]  timer, timer_n;
   logic [3:0]     bit_cnt, bit_cnt_n;
   logic [WCW-1:0] word_cnt, word_cnt_n;
   logic [PCW-1:0] pulse_cnt, pulse_cnt_n;

   logic di_n, dck_n, busy_n, word_done_n, frame_done_n, overrun_n;

   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         state            <= ST_IDLE;
         shreg            <= '0;
         timer            <= '0;
         bit_cnt          <= '0;
         word_cnt         <= '0;
         pulse_cnt        <= '0;
         my9262_DI        <= 1'b0;
         my9262_DCK       <= 1'b0;
         my9262_Busy      <= 1'b0;
         my9262_WordDone  <= 1'b0;
         my9262_FrameDone <= 1'b0;
         my9262_Overrun   <= 1'b0;
      end else begin
         state            <= state_n;
         shreg            <= shreg_n;
         timer            <= timer_n;
         bit_cnt          <= bit_cnt_n;
         word_cnt         <= word_cnt_n;
         pulse_cnt        <= pulse_cnt_n;
         my9262_DI        <= di_n;
         my9262_DCK       <= dck_n;
         my9262_Busy      <= busy_n;
         my9262_WordDone  <= word_done_n;
         my9262_FrameDone <= frame_done_n;
         my9262_Overrun   <= overrun_n;
      end
   end

   always_comb begin
      state_n      = state;
      shreg_n      = shreg;
      timer_n      = timer;
      bit_cnt_n    = bit_cnt;
      word_cnt_n   = word_cnt;
      pulse_cnt_n  = pulse_cnt;
      word_done_n  = 1'b0;
      frame_done_n = 1'b0;
      // Acceptance looks only at the registered state, so a start landing on
      // the edge that returns to idle still counts as an overrun.
      overrun_n    = my9262_Overrun | (my9262_Start && (state != ST_IDLE));

      case (state)
         ST_IDLE: begin
            if (my9262_Start) begin
               state_n   = ST_SHIFT_LO;
               shreg_n   = my9262_Data;
               timer_n   = DIV_LOAD;
               bit_cnt_n = '0;
            end
         end

         ST_SHIFT_LO: begin
            if (timer == '0) begin
               state_n = ST_SHIFT_HI;
               timer_n = DIV_LOAD;
            end else begin
               timer_n = timer - TW'(1);
            end
         end

         ST_SHIFT_HI: begin
            if (timer == '0) begin
               shreg_n   = {shreg[14:0], 1'b0};
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt != 4'd15) begin
                  state_n = ST_SHIFT_LO;
                  timer_n = DIV_LOAD;
               end else begin
                  word_done_n = 1'b1;
                  if (word_cnt == WORD_LAST) begin
                     word_cnt_n = '0;
                     state_n    = ST_LATCH_WAIT;
                     timer_n    = WAIT_LOAD;
                  end else begin
                     word_cnt_n = word_cnt + WCW'(1);
                     state_n    = ST_IDLE;
                  end
               end
            end else begin
               timer_n = timer - TW'(1);
            end
         end

         ST_LATCH_WAIT: begin
            if (timer == '0) begin
               state_n     = ST_LATCH_HI;
               timer_n     = DIV_LOAD;
               pulse_cnt_n = '0;
            end else begin
               timer_n = timer - TW'(1);
            end
         end

         ST_LATCH_HI: begin
            if (timer == '0) begin
               state_n = ST_LATCH_LO;
               timer_n = DIV_LOAD;
            end else begin
               timer_n = timer - TW'(1);
            end
         end

         ST_LATCH_LO: begin
            if (timer == '0) begin
               if (pulse_cnt == PULSE_LAST) begin
                  pulse_cnt_n  = '0;
                  frame_done_n = 1'b1;
                  state_n      = ST_IDLE;
               end else begin
                  pulse_cnt_n = pulse_cnt + PCW'(1);
                  state_n     = ST_LATCH_HI;
                  timer_n     = DIV_LOAD;
               end
            end else begin
               timer_n = timer - TW'(1);
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // Pin values are decoded from the next state so that every output
      // comes straight from a flop.
      busy_n = (state_n != ST_IDLE);
      dck_n  = (state_n == ST_SHIFT_HI);
      case (state_n)
         ST_SHIFT_LO, ST_SHIFT_HI: di_n = shreg_n[15];
         ST_LATCH_HI:              di_n = 1'b1;
         default:                  di_n = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_my9262_serializer.sv
module tb_my9262_serializer;

   // Instance A: general configuration; instance B: fastest clock, one-word chain.
   localparam int A_DIV = 2, A_CW = 2, A_LW = 8, A_LP = 4;
   localparam int B_DIV = 1, B_CW = 1, B_LW = 4, B_LP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] data;

   logic di_a, dck_a, busy_a, wd_a, fd_a, ovr_a;
   logic di_b, dck_b, busy_b, wd_b, fd_b, ovr_b;

   always #5 clk = ~clk;

   my9262_serializer #(.CLK_DIV(A_DIV), .CHAIN_WORDS(A_CW), .LATCH_WAIT(A_LW), .LATCH_PULSES(A_LP)) dut_a (
      .csi_clk(clk), .rsi_reset(rst), .my9262_Data(data), .my9262_Start(start),
      .my9262_DI(di_a), .my9262_DCK(dck_a), .my9262_Busy(busy_a),
      .my9262_WordDone(wd_a), .my9262_FrameDone(fd_a), .my9262_Overrun(ovr_a));

   my9262_serializer #(.CLK_DIV(B_DIV), .CHAIN_WORDS(B_CW), .LATCH_WAIT(B_LW), .LATCH_PULSES(B_LP)) dut_b (
      .csi_clk(clk), .rsi_reset(rst), .my9262_Data(data), .my9262_Start(start),
      .my9262_DI(di_b), .my9262_DCK(dck_b), .my9262_Busy(busy_b),
      .my9262_WordDone(wd_b), .my9262_FrameDone(fd_b), .my9262_Overrun(ovr_b));

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Reference model: each accepted word expands into the full expected
   // waveform, one entry per cycle, as {di, dck, busy, word_done, frame_done}.
   logic [4:0] qa[$];
   logic [4:0] qb[$];
   logic [4:0] cur  [2];
   bit         movr [2];
   int         widx [2];

   function automatic int p_div(input int i); return (i == 0) ? A_DIV : B_DIV; endfunction
   function automatic int p_cw (input int i); return (i == 0) ? A_CW  : B_CW;  endfunction
   function automatic int p_lw (input int i); return (i == 0) ? A_LW  : B_LW;  endfunction
   function automatic int p_lp (input int i); return (i == 0) ? A_LP  : B_LP;  endfunction

   function automatic void push(input int i, input logic [4:0] v);
      if (i == 0) qa.push_back(v);
      else        qb.push_back(v);
   endfunction

   function automatic void gen_word(input int i, input logic [15:0] d);
      for (int b = 15; b >= 0; b--) begin
         for (int k = 0; k < p_div(i); k++) push(i, {d[b], 1'b0, 1'b1, 1'b0, 1'b0});
         for (int k = 0; k < p_div(i); k++) push(i, {d[b], 1'b1, 1'b1, 1'b0, 1'b0});
      end
      if (widx[i] == p_cw(i) - 1) begin
         widx[i] = 0;
         push(i, 5'b00110);
         for (int k = 1; k < p_lw(i); k++) push(i, 5'b00100);
         for (int p = 0; p < p_lp(i); p++) begin
            for (int k = 0; k < p_div(i); k++) push(i, 5'b10100);
            for (int k = 0; k < p_div(i); k++) push(i, 5'b00100);
         end
         push(i, 5'b00001);
      end else begin
         widx[i] = widx[i] + 1;
         push(i, 5'b00010);
      end
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            if (i == 0) qa.delete(); else qb.delete();
            cur[i]  = 5'b0;
            movr[i] = 1'b0;
            widx[i] = 0;
         end else begin
            if (start) begin
               if (cur[i][2]) movr[i] = 1'b1;
               else           gen_word(i, data);
            end
            if (i == 0) cur[i] = (qa.size() > 0) ? qa.pop_front() : 5'b0;
            else        cur[i] = (qb.size() > 0) ? qb.pop_front() : 5'b0;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({di_a, dck_a, busy_a, wd_a, fd_a, ovr_a} !== {cur[0], movr[0]}) begin
            failures++;
            $display("FAIL cycle_a t=%0t di/dck/busy/wd/fd/ovr got=%b need=%b", $time,
                     {di_a, dck_a, busy_a, wd_a, fd_a, ovr_a}, {cur[0], movr[0]});
         end
         checks++;
         if ({di_b, dck_b, busy_b, wd_b, fd_b, ovr_b} !== {cur[1], movr[1]}) begin
            failures++;
            $display("FAIL cycle_b t=%0t di/dck/busy/wd/fd/ovr got=%b need=%b", $time,
                     {di_b, dck_b, busy_b, wd_b, fd_b, ovr_b}, {cur[1], movr[1]});
         end
      end
   end

   // Pin monitors: bits sampled on DCK rises, DI rises, FrameDone pulses.
   logic [15:0] sr_a = 16'h0, sr_b = 16'h0;
   logic        pdck_a = 1'b0, pdck_b = 1'b0, pdi_a = 1'b0;
   int          di_rise_a = 0, fd_cnt_b = 0;

   always @(posedge clk) begin
      if (dck_a === 1'b1 && pdck_a === 1'b0) sr_a = {sr_a[14:0], di_a};
      if (dck_b === 1'b1 && pdck_b === 1'b0) sr_b = {sr_b[14:0], di_b};
      if (di_a === 1'b1 && pdi_a === 1'b0) di_rise_a++;
      if (fd_b === 1'b1) fd_cnt_b++;
      pdck_a = dck_a;
      pdck_b = dck_b;
      pdi_a  = di_a;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h need=%0h", name, act, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return wd_a;
         1:       return fd_a;
         2:       return wd_b;
         3:       return fd_b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int which, input int bound, input string name, output int n);
      n = 0;
      while (sig(which) !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (sig(which) !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s timeout got=%0d cycles need=event", name, n);
      end
   endtask

   task automatic pulse(input logic [15:0] d);
      start = 1'b1;
      data  = d;
      @(negedge clk);
      start = 1'b0;
      data  = 16'($urandom);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst   = 1'b1;
      start = 1'b0;
      data  = 16'h0;
      repeat (3) @(negedge clk);
      check("reset_outputs_a", {di_a, dck_a, busy_a, wd_a, fd_a, ovr_a}, 0);
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // Word A5C3, first word of the frame: no latch afterwards.
      pulse(16'hA5C3);
      check("t1_first_di", {di_a, dck_a, busy_a}, 3'b101);
      wait_for(0, 200, "t1_worddone", n);
      check("t1_word_cycles", n, 64);
      check("t1_bits", sr_a, 16'hA5C3);
      check("t1_busy_after", busy_a, 0);

      // Word 0001 closes the frame: quiet period then latch pulses.
      @(negedge clk);
      pulse(16'h0001);
      wait_for(0, 200, "t2_worddone", n);
      check("t2_bits", sr_a, 16'h0001);
      check("t2_busy_latch", busy_a, 1);
      di_rise_a = 0;
      wait_for(1, 200, "t2_framedone", n);
      check("t2_latch_cycles", n, A_LW + 2 * A_DIV * A_LP);
      check("t2_latch_pulses", di_rise_a, A_LP);
      check("t2_ovr_clear", ovr_a, 0);
      @(negedge clk);
      check("t2_idle", {di_a, dck_a, busy_a, fd_a}, 0);

      // A start while shifting is ignored and sets the sticky overrun.
      pulse(16'hFFFF);
      repeat (9) @(negedge clk);
      pulse(16'h0000);
      check("t3_overrun_set", ovr_a, 1);
      wait_for(0, 200, "t3_worddone", n);
      check("t3_bits", sr_a, 16'hFFFF);
      @(negedge clk);
      pulse(16'h1234);
      wait_for(0, 200, "t3_worddone2", n);
      check("t3_bits2", sr_a, 16'h1234);
      wait_for(1, 200, "t3_framedone", n);
      check("t3_overrun_held", ovr_a, 1);
      @(negedge clk);

      // Reset mid-word aborts and restarts the frame.
      pulse(16'h8000);
      repeat (20) @(negedge clk);
      do_reset(1);
      check("t4_reset_pins", {di_a, dck_a, busy_a, ovr_a}, 0);
      pulse(16'h8001);
      wait_for(0, 200, "t4_worddone", n);
      check("t4_bits", sr_a, 16'h8001);
      check("t4_no_latch", busy_a, 0);
      @(negedge clk);
      pulse(16'h7FFE);
      wait_for(0, 200, "t4_worddone2", n);
      check("t4_latch_now", busy_a, 1);
      wait_for(1, 200, "t4_framedone", n);
      @(negedge clk);

      // Start landing on the idle-return edge is an overrun; one cycle later it is accepted.
      pulse(16'h0F0F);
      repeat (63) @(negedge clk);
      check("t5_pre_ovr", ovr_a, 0);
      pulse(16'h4444);
      check("t5_edge_wd", {wd_a, busy_a, ovr_a}, 3'b101);
      pulse(16'h8000);
      check("t5_accept", {di_a, busy_a}, 2'b11);
      wait_for(0, 200, "t5_worddone", n);
      check("t5_bits", sr_a, 16'h8000);
      wait_for(1, 200, "t5_framedone", n);

      // Instance B: DCK toggles every cycle, latch after every word.
      do_reset(2);
      fd_cnt_b = 0;
      pulse(16'h5555);
      check("t6_first", {di_b, dck_b, busy_b}, 3'b001);
      @(negedge clk);
      check("t6_dck_toggle", {di_b, dck_b}, 2'b01);
      wait_for(2, 200, "t6_worddone", n);
      check("t6_word_cycles", n, 31);
      check("t6_bits", sr_b, 16'h5555);
      wait_for(3, 200, "t6_framedone", n);
      check("t6_latch_cycles", n, B_LW + 2 * B_DIV * B_LP);
      repeat (20) @(negedge clk);
      check("t6_fd_once", fd_cnt_b, 1);

      // Random traffic, checked cycle by cycle against the model.
      for (int c = 0; c < 5000; c++) begin
         start = ($urandom_range(0, 39) == 0);
         data  = 16'($urandom);
         rst   = ($urandom_range(0, 799) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
      repeat (300) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/my9262_serializer.md
Name: my9262_serializer

Overview:
Downstream consumer of the MY9262 Avalon register stage. It takes each 16-bit grayscale word and its one-cycle start strobe, and shifts the word MSB-first onto the MY9262 DI/DCK pins. After CHAIN_WORDS words it runs the internal-latch sequence: a quiet period, then a train of DI pulses with DCK held low. It exposes busy, done and overrun status so software or the register stage can pace writes.

Parameters:
CLK_DIV, 4, csi_clk cycles per DCK half-period (>=1)
CHAIN_WORDS, 16, words shifted per frame before the latch sequence (>=1)
LATCH_WAIT, 64, csi_clk cycles with DI=0 and DCK=0 before the latch pulses
LATCH_PULSES, 4, number of DI pulses in the latch sequence

Ports:
csi_clk  input  1  system clock
rsi_reset  input  1  reset; synchronous, active-high
my9262_Data  input  16  word to shift; sampled only on an accepted start
my9262_Start  input  1  one-cycle start strobe for one word
my9262_DI  output  1  serial data / latch pulses to the MY9262
my9262_DCK  output  1  serial clock to the MY9262
my9262_Busy  output  1  high while shifting or latching
my9262_WordDone  output  1  one-cycle pulse after each word's last DCK falling edge
my9262_FrameDone  output  1  one-cycle pulse at the end of the latch sequence
my9262_Overrun  output  1  sticky; set when a start arrives while Busy=1

Behaviour:
- One clock, csi_clk. rsi_reset is synchronous and active-high.
- While rsi_reset=1 at a rising edge: state=IDLE, all outputs 0, shift register 0, bit/word/latch counters 0, Overrun cleared.
- All outputs are registered.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH_WAIT, LATCH_HI, LATCH_LO.
- IDLE:
  - Start=1 loads Data into the shift register, sets Busy, and enters SHIFT_LO at the same edge.
  - DI=bit15 is visible the following cycle.
- SHIFT_LO: DCK=0 and DI=current MSB for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: DCK=1 for CLK_DIV cycles, DI stable.
  - On exit: shift left by 1 and increment the bit counter.
  - If the bit counter was not 15, go to SHIFT_LO.
  - If it was 15:
    - Drive DCK=0 and DI=0, pulse WordDone.
    - Word counter == CHAIN_WORDS-1: reset the word counter to 0 and go to LATCH_WAIT.
    - Otherwise: increment the word counter, drop Busy and return to IDLE.
- Word timing: 2*CLK_DIV*16 cycles from the first DI-valid cycle to the WordDone cycle, inclusive of the final DCK-high phase.
- DI changes only while DCK=0 (setup of CLK_DIV cycles before the DCK rise).
- LATCH_WAIT: DI=0, DCK=0, Busy=1 for LATCH_WAIT cycles, then go to LATCH_HI.
- LATCH_HI: DI=1 for CLK_DIV cycles. LATCH_LO: DI=0 for CLK_DIV cycles. Repeat for LATCH_PULSES pulses.
- After the last LATCH_LO: pulse FrameDone for one cycle, drop Busy, return to IDLE.
- DCK stays 0 throughout the latch sequence.
- Start while Busy=1 (any non-IDLE state):
  - The word is ignored.
  - The shift register, counters and state are unaffected.
  - Overrun becomes 1 the next cycle and stays 1 until reset.
- Start in the same cycle that Busy falls (the IDLE-return edge): Busy is still 1 at that edge, so this is an overrun. Start is accepted only when the registered state is IDLE.
- Reset mid-word or mid-latch: abort immediately. DI=DCK=0 the next cycle and the word counter is cleared, so the next start begins a fresh frame.
- Data changing while shifting has no effect; only the value captured at acceptance is shifted.
- No X propagation: the DI value in IDLE is 0, regardless of Data.

Test Plan:
1. CLK_DIV=2, CHAIN_WORDS=2. Reset, then Start with Data=16'hA5C3 -> DI bit sequence 1010_0101_1100_0011 sampled on each DCK rise; 16 DCK pulses, each high 2 cycles; WordDone at 64 cycles after DI first valid; Busy then falls and no latch occurs.
2. Continuing from test 1, Start with Data=16'h0001 -> 15 zeros then a 1 on DCK rises; WordDone; then DI=0/DCK=0 for 8 cycles (LATCH_WAIT=8); 4 DI pulses each 2 cycles high and 2 low; FrameDone one cycle; Busy=0.
3. Start with Data=16'hFFFF, then a second Start 10 cycles later with 16'h0000 -> output is still 16 ones; Overrun=1 from the cycle after the second Start and held through a further accepted word.
4. Start with 16'h8000, assert rsi_reset for 1 cycle at bit 5, release, then Start with 16'h8001 -> DI/DCK/Busy=0 the cycle after reset; new word shifts fully; the latch occurs only after CHAIN_WORDS further words.
5. Start pulsed exactly on the WordDone/IDLE-return edge, then Start 1 cycle later -> first Start flagged as overrun; second accepted, and its MSB appears 1 cycle after that Start.
6. CLK_DIV=1, CHAIN_WORDS=1, Data=16'h5555 -> DCK toggles every cycle, 32-cycle word, immediate latch sequence, FrameDone asserted once.
